bram_latency_ctrl: RTL

Single-port 32-bit word memory controller placed directly downstream of the arbiter; one instance for u0 (instructions/BSS/raw data) and one for u1 (processed data). It accepts at most one read or write per cycle and commits writes immediately. Reads return after a fixed `DELAYS`-cycle pipeline that models the slow on-chip BRAM. Each returned word is flagged to the reader selected at request time: the CPU/FIFO side or the DMA side.

---
 rtl/bram_latency_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/bram_latency_ctrl.sv
// Single-port 32-bit word memory with writes committed at once and reads returned DELAYS cycles later, each tagged for the CPU/FIFO or DMA reader.
// One request accepted per cycle, no back-pressure.
module bram_latency_ctrl #(
   parameter int DELAYS = 10,
   parameter int DEPTH  = 8192
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        in_valid,
   input  logic        wr,
   input  logic [12:0] addr,
   input  logic [31:0] data_in,
   input  logic        reader_sel,
   output logic [31:0] data_out,
   output logic        cpu_get_data,
   output logic        dma_get_data,
   output logic [3:0]  inflight,
   output logic        addr_err
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic          in_range;
   logic          accept;
   logic          rd_acc;
   logic          wr_acc;
   logic          deliver;
   logic          pipe_vld [DELAYS];
   logic          pipe_sel [DELAYS];
   logic [31:0]   pipe_dat [DELAYS];
   logic [31:0]   hold_dat;

   assign in_range = {19'd0, addr} < 32'(DEPTH);
   assign idx      = addr[AW-1:0];
   assign accept   = in_valid & ~wb_rst_i;
   assign rd_acc   = accept & ~wr;
   assign wr_acc   = accept & wr & in_range;

   // Read data is snapshotted at acceptance, so later writes cannot reach an in-flight read.
   always_ff @(posedge wb_clk_i) begin
      if (wr_acc) begin
         mem[idx] <= data_in;
      end
      pipe_dat[0] <= in_range ? mem[idx] : 32'd0;
      for (int i = 1; i < DELAYS; i++) begin
         pipe_dat[i] <= pipe_dat[i-1];
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < DELAYS; i++) begin
            pipe_vld[i] <= 1'b0;
            pipe_sel[i] <= 1'b0;
         end
         hold_dat <= 32'd0;
         inflight <= 4'd0;
         addr_err <= 1'b0;
      end else begin
         pipe_vld[0] <= rd_acc;
         pipe_sel[0] <= reader_sel;
         for (int i = 1; i < DELAYS; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_sel[i] <= pipe_sel[i-1];
         end
         if (deliver) begin
            hold_dat <= pipe_dat[DELAYS-1];
         end
         if (rd_acc && !deliver) begin
            inflight <= inflight + 4'd1;
         end else if (!rd_acc && deliver) begin
            inflight <= inflight - 4'd1;
         end
         if (in_valid && !in_range) begin
            addr_err <= 1'b1;
         end
      end
   end

   // The last stage drives the outputs directly; hold_dat keeps the word visible afterwards.
   assign deliver      = pipe_vld[DELAYS-1];
   assign cpu_get_data = deliver & pipe_sel[DELAYS-1];
   assign dma_get_data = deliver & ~pipe_sel[DELAYS-1];
   assign data_out     = deliver ? pipe_dat[DELAYS-1] : hold_dat;

endmodule
